// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
// Imported by the state-to-control decoder and the controller top.
package mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t StFetch  = 4'd0;
    localparam state_t StDecode = 4'd1;
    localparam state_t StMemAdr = 4'd2;
    localparam state_t StMemRd  = 4'd3;
    localparam state_t StMemWb  = 4'd4;
    localparam state_t StMemWr  = 4'd5;
    localparam state_t StExecR  = 4'd6;
    localparam state_t StExecI  = 4'd7;
    localparam state_t StLui    = 4'd8;
    localparam state_t StAuipc  = 4'd9;
    localparam state_t StAluWb  = 4'd10;
    localparam state_t StBranch = 4'd11;
    localparam state_t StJalAdr = 4'd12;
    localparam state_t StJal    = 4'd13;
    localparam state_t StTrap   = 4'd14;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [1:0] SrcaPc    = 2'd0;
    localparam logic [1:0] SrcaOldPc = 2'd1;
    localparam logic [1:0] SrcaRs1   = 2'd2;
    localparam logic [1:0] SrcaZero  = 2'd3;

    localparam logic [1:0] SrcbRs2  = 2'd0;
    localparam logic [1:0] SrcbImm  = 2'd1;
    localparam logic [1:0] SrcbFour = 2'd2;

    localparam logic [1:0] ResAluOut = 2'd0;
    localparam logic [1:0] ResMem    = 2'd1;
    localparam logic [1:0] ResAlu    = 2'd2;

    localparam logic [1:0] AluAdd    = 2'd0;
    localparam logic [1:0] AluBranch = 2'd1;
    localparam logic [1:0] AluDecode = 2'd2;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_we;
        logic       mem_req;
        logic       addr_src;
        logic [1:0] alu_srca;
        logic [1:0] alu_srcb;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Pure state-to-control map; strobes here are unqualified and get gated
// by handshake inputs and reset in mc_ctrl.
module mc_outdec
    import mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.mem_req    = 1'b1;
                ctrl.ir_we      = 1'b1;
                ctrl.pc_we      = 1'b1;
                ctrl.alu_srca   = SrcaPc;
                ctrl.alu_srcb   = SrcbFour;
                ctrl.result_src = ResAlu;
                ctrl.alu_op     = AluAdd;
            end
            StDecode: begin
                ctrl.alu_srca = SrcaOldPc;
                ctrl.alu_srcb = SrcbImm;
            end
            StMemAdr, StExecI, StJalAdr: begin
                ctrl.alu_srca = SrcaRs1;
                ctrl.alu_srcb = SrcbImm;
                ctrl.alu_op   = (state == StExecI) ? AluDecode : AluAdd;
            end
            StMemRd: begin
                ctrl.mem_req  = 1'b1;
                ctrl.addr_src = 1'b1;
            end
            StMemWb: begin
                ctrl.result_src = ResMem;
                ctrl.reg_we     = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_we   = 1'b1;
                ctrl.addr_src = 1'b1;
            end
            StExecR: begin
                ctrl.alu_srca = SrcaRs1;
                ctrl.alu_srcb = SrcbRs2;
                ctrl.alu_op   = AluDecode;
            end
            StLui: begin
                ctrl.alu_srca = SrcaZero;
                ctrl.alu_srcb = SrcbImm;
            end
            StAuipc: begin
                ctrl.alu_srca = SrcaOldPc;
                ctrl.alu_srcb = SrcbImm;
            end
            StAluWb: begin
                ctrl.result_src = ResAluOut;
                ctrl.reg_we     = 1'b1;
            end
            StBranch: begin
                ctrl.alu_srca   = SrcaRs1;
                ctrl.alu_srcb   = SrcbRs2;
                ctrl.alu_op     = AluBranch;
                ctrl.result_src = ResAluOut;
                ctrl.pc_we      = 1'b1;
            end
            StJal: begin
                ctrl.pc_we      = 1'b1;
                ctrl.result_src = ResAluOut;
                ctrl.alu_srca   = SrcaOldPc;
                ctrl.alu_srcb   = SrcbFour;
            end
            StTrap: begin
                ctrl.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: state register, opcode dispatch and
// memory-ready / branch-condition qualification of the write strobes.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       alu_cond,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_we,
    output logic       mem_req,
    output logic       addr_src,
    output logic [1:0] alu_srca,
    output logic [1:0] alu_srcb,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       illegal
);

    state_t state_q, state_d;
    ctrl_t  dflt;

    mc_outdec u_outdec (
        .state (state_q),
        .ctrl  (dflt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalAdr;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: state_d = (opcode == OpStore) ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExecR, StExecI, StLui, StAuipc: state_d = StAluWb;
            StJalAdr: state_d = StJal;
            StJal:    state_d = StAluWb;
            StMemWb, StAluWb, StBranch: state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StTrap;
        endcase
    end

    logic pc_qual;

    always_comb begin
        pc_qual = 1'b1;
        if (state_q == StFetch) begin
            pc_qual = mem_ready;
        end else if (state_q == StBranch) begin
            pc_qual = alu_cond;
        end
    end

    // Strobes are gated by reset so nothing writes in the reset-assert cycle.
    assign pc_we   = reset & dflt.pc_we & pc_qual;
    assign ir_we   = reset & dflt.ir_we & mem_ready;
    assign reg_we  = reset & dflt.reg_we;
    assign mem_we  = reset & dflt.mem_we;
    assign mem_req = reset & dflt.mem_req;
    assign illegal = reset & dflt.illegal;

    assign addr_src   = dflt.addr_src;
    assign alu_srca   = dflt.alu_srca;
    assign alu_srcb   = dflt.alu_srcb;
    assign result_src = dflt.result_src;
    assign alu_op     = dflt.alu_op;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus queues hand-written per-cycle
// expected control vectors, a negedge monitor pops and compares them.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_we;
        logic       mem_req;
        logic       addr_src;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] aluop;
        logic       illegal;
    } out_t;

    function automatic out_t o(int pc, int ir, int rw, int mw, int mr, int as_,
                               int sa, int sb, int rs, int ao, int il);
        out_t r;
        r.pc_we    = pc[0];
        r.ir_we    = ir[0];
        r.reg_we   = rw[0];
        r.mem_we   = mw[0];
        r.mem_req  = mr[0];
        r.addr_src = as_[0];
        r.srca     = sa[1:0];
        r.srcb     = sb[1:0];
        r.res      = rs[1:0];
        r.aluop    = ao[1:0];
        r.illegal  = il[0];
        return r;
    endfunction

    //                                 pc ir rw mw mr as sa sb rs ao il
    localparam out_t ERst      = o(0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0);
    localparam out_t EFetchW   = o(0, 0, 0, 0, 1, 0, 0, 2, 2, 0, 0);
    localparam out_t EFetch    = o(1, 1, 0, 0, 1, 0, 0, 2, 2, 0, 0);
    localparam out_t EDecode   = o(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    localparam out_t EMemAdr   = o(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    localparam out_t EMemRd    = o(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    localparam out_t EMemWb    = o(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    localparam out_t EMemWr    = o(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    localparam out_t EExecR    = o(0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0);
    localparam out_t EExecI    = o(0, 0, 0, 0, 0, 0, 2, 1, 0, 2, 0);
    localparam out_t ELui      = o(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    localparam out_t EAuipc    = o(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    localparam out_t EAluWb    = o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam out_t EBrTaken  = o(1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0);
    localparam out_t EBrNot    = o(0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0);
    localparam out_t EJalAdr   = o(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    localparam out_t EJal      = o(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    localparam out_t ETrap     = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       alu_cond;
    logic       pc_we, ir_we, reg_we, mem_we, mem_req, addr_src, illegal;
    logic [1:0] alu_srca, alu_srcb, result_src, alu_op;

    int total = 0;
    int bad   = 0;

    out_t  exp_q[$];
    string name_q[$];
    out_t  act;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .alu_cond   (alu_cond),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .mem_we     (mem_we),
        .mem_req    (mem_req),
        .addr_src   (addr_src),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .result_src (result_src),
        .alu_op     (alu_op),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign act = {pc_we, ir_we, reg_we, mem_we, mem_req, addr_src,
                  alu_srca, alu_srcb, result_src, alu_op, illegal};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got %b expected %b (pc ir rw mw mr as sa sb rs ao il)",
                         nm, act, e);
            end
        end
    end

    task automatic step(input logic [6:0] op, input logic mr, input logic ac,
                        input out_t e, input string nm);
        opcode    = op;
        mem_ready = mr;
        alu_cond  = ac;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic seq4(input logic [6:0] op, input out_t e3, input string nm);
        step(op, 1'b1, 1'b0, EFetch,  {nm, "_fetch"});
        step(op, 1'b1, 1'b0, EDecode, {nm, "_decode"});
        step(op, 1'b1, 1'b0, e3,      {nm, "_exec"});
        step(op, 1'b1, 1'b0, EAluWb,  {nm, "_wb"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        opcode    = 7'b0;
        mem_ready = 1'b1;
        alu_cond  = 1'b0;
        #1;
        exp_q.push_back(ERst);
        name_q.push_back("reset_strobes");
        #11;
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        step(7'b0110011, 1'b0, 1'b0, EFetchW, "first_fetch_wait");
        seq4(7'b0110011, EExecR, "rtype");
        seq4(7'b0010011, EExecI, "itype");
        seq4(7'b0110111, ELui,   "lui");
        seq4(7'b0010111, EAuipc, "auipc");

        // Load with two wait cycles in MEMRD: seven cycles total.
        step(7'b0000011, 1'b1, 1'b0, EFetch,  "ld_fetch");
        step(7'b0000011, 1'b1, 1'b0, EDecode, "ld_decode");
        step(7'b0000011, 1'b1, 1'b0, EMemAdr, "ld_memadr");
        step(7'b0000011, 1'b0, 1'b0, EMemRd,  "ld_memrd0");
        step(7'b0000011, 1'b0, 1'b0, EMemRd,  "ld_memrd1");
        step(7'b0000011, 1'b1, 1'b0, EMemRd,  "ld_memrd2");
        step(7'b0000011, 1'b1, 1'b0, EMemWb,  "ld_memwb");

        step(7'b0100011, 1'b1, 1'b0, EFetch,  "st_fetch");
        step(7'b0100011, 1'b1, 1'b0, EDecode, "st_decode");
        step(7'b0100011, 1'b1, 1'b0, EMemAdr, "st_memadr");
        step(7'b0100011, 1'b0, 1'b0, EMemWr,  "st_memwr_wait");
        step(7'b0100011, 1'b1, 1'b0, EMemWr,  "st_memwr_done");

        step(7'b1100011, 1'b1, 1'b1, EFetch,   "bt_fetch");
        step(7'b1100011, 1'b1, 1'b1, EDecode,  "bt_decode");
        step(7'b1100011, 1'b1, 1'b1, EBrTaken, "bt_branch");
        step(7'b1100011, 1'b1, 1'b0, EFetch,   "bn_fetch");
        step(7'b1100011, 1'b1, 1'b0, EDecode,  "bn_decode");
        step(7'b1100011, 1'b1, 1'b0, EBrNot,   "bn_branch");

        step(7'b1100111, 1'b1, 1'b0, EFetch,  "jalr_fetch");
        step(7'b1100111, 1'b1, 1'b0, EDecode, "jalr_decode");
        step(7'b1100111, 1'b1, 1'b0, EJalAdr, "jalr_adr");
        step(7'b1100111, 1'b1, 1'b0, EJal,    "jalr_jal");
        step(7'b1100111, 1'b1, 1'b0, EAluWb,  "jalr_wb");

        seq4(7'b1101111, EJal, "jal");

        // Reset asserted mid-store must kill mem_we at once.
        step(7'b0100011, 1'b1, 1'b0, EFetch,  "ab_fetch");
        step(7'b0100011, 1'b1, 1'b0, EDecode, "ab_decode");
        step(7'b0100011, 1'b1, 1'b0, EMemAdr, "ab_memadr");
        step(7'b0100011, 1'b0, 1'b0, EMemWr,  "ab_memwr");
        reset = 1'b0;
        step(7'b0100011, 1'b1, 1'b0, ERst, "ab_reset");
        reset = 1'b1;
        step(7'b0100011, 1'b1, 1'b0, EFetch, "ab_refetch");

        step(7'b1111111, 1'b1, 1'b0, EDecode, "trap_decode");
        for (int i = 0; i < 20; i++) begin
            step(7'b1111111, 1'b1, 1'b1, ETrap, "trap_hold");
        end
        reset = 1'b0;
        step(7'b1111111, 1'b1, 1'b0, ERst, "trap_reset");
        reset = 1'b1;
        step(7'b0110011, 1'b1, 1'b0, EFetch,  "post_trap_fetch");
        step(7'b0110011, 1'b1, 1'b0, EDecode, "post_trap_decode");

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM that sequences the shared RV32I datapath (PC register, instruction register, regfile, ALU, unified memory port) over several cycles per instruction, replacing the single-cycle main/sub decoders. Each cycle it emits register write enables, mux selects, ALU mode and a memory request, and it stalls on a ready handshake from the memory port.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `opcode`  in  7  instr[6:0] from instruction register
- `mem_ready`  in  1  memory completes current request this cycle
- `alu_cond`  in  1  branch condition from ALU (valid in BRANCH)
- `pc_we`, `ir_we`, `reg_we`, `mem_we`  out  1 each  write strobes
- `mem_req`  out  1  memory access request
- `addr_src`  out  1  0 = PC, 1 = ALUOut register
- `alu_srca`  out  2  0 = PC, 1 = OldPC, 2 = rs1 reg, 3 = zero
- `alu_srcb`  out  2  0 = rs2 reg, 1 = imm, 2 = const 4
- `result_src`  out  2  0 = ALUOut reg, 1 = mem data, 2 = ALU result
- `alu_op`  out  2  0 = add, 1 = branch compare, 2 = decode funct3/funct7
- `illegal`  out  1  sticky illegal-opcode flag

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, LUI, AUIPC, ALUWB, BRANCH, JALADR, JAL, TRAP.
- FETCH: mem_req=1, addr_src=0, srca=PC, srcb=4, add, result_src=2. On mem_ready: ir_we=1, pc_we=1, go to DECODE. Otherwise hold.
- DECODE: srca=OldPC, srcb=imm, add (branch/JAL target into ALUOut). Dispatch on opcode:
  - 0000011 and 0100011 go to MEMADR.
  - 0110011 goes to EXECR. 0010011 goes to EXECI.
  - 0110111 goes to LUI. 0010111 goes to AUIPC.
  - 1100011 goes to BRANCH. 1101111 goes to JAL. 1100111 goes to JALADR.
  - Any other opcode goes to TRAP.
- MEMADR: srca=rs1, srcb=imm, add. Go to MEMRD for a load, MEMWR for a store.
- MEMRD: mem_req=1, addr_src=1. Go to MEMWB on mem_ready.
- MEMWB: result_src=1, reg_we=1, go to FETCH.
- MEMWR: mem_req=1, mem_we=1, addr_src=1. Go to FETCH on mem_ready.
- EXECR: srca=rs1, srcb=rs2, alu_op=2, go to ALUWB.
- EXECI: srca=rs1, srcb=imm, alu_op=2, go to ALUWB.
- LUI: srca=zero, srcb=imm, add, go to ALUWB.
- AUIPC: srca=OldPC, srcb=imm, add, go to ALUWB.
- ALUWB: result_src=0, reg_we=1, go to FETCH.
- BRANCH: srca=rs1, srcb=rs2, alu_op=1, result_src=0, pc_we=alu_cond, go to FETCH.
- JALADR: srca=rs1, srcb=imm, add, go to JAL.
- JAL: result_src=0, pc_we=1, srca=OldPC, srcb=4, add, go to ALUWB (writes the link address OldPC+4).
- TRAP: all strobes 0, illegal=1. Stays in TRAP until reset.
- Selects not listed for a state are 0.

## Timing
- While reset is low:
  - state = FETCH.
  - pc_we, ir_we, reg_we, mem_we, mem_req and illegal are all 0; the strobes are combinationally gated by reset.
  - Selects show their FETCH values: addr_src=0, srca=0, srcb=2, result_src=2, alu_op=0.
- First mem_req appears in the cycle reset deasserts.
- Outputs are Moore (functions of state), with three exceptions:
  - FETCH ir_we and pc_we are qualified by mem_ready.
  - BRANCH pc_we is qualified by alu_cond.
  - mem_we is held for the whole of MEMWR, not only the completing cycle.
- Latency with zero-wait memory:
  - R/I/LUI/AUIPC/store: 4 cycles.
  - Load: 5 cycles.
  - Branch: 3 cycles.
  - JAL: 4 cycles. JALR: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- Handshake: mem_req stays high with stable addr_src until the mem_ready cycle. mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Async reset mid-instruction aborts it. No partial write may occur after reset asserts.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - opcode localparams;
  - encodings for srca, srcb, result_src and alu_op.
- Sub-module `mc_outdec` is a combinational map from state to select/strobe defaults. `mc_ctrl` keeps the state register, next-state logic and handshake qualification.

## Test plan
- Reset held low for 12 ns, then released:
  - all strobes are 0 during reset;
  - mem_req=1 in the first cycle after release;
  - with mem_ready=1, pc_we and ir_we pulse and the next state is DECODE.
- opcode 0110011 with mem_ready=1 always: state sequence FETCH, DECODE, EXECR, ALUWB, with reg_we=1 only in ALUWB and result_src=0.
- opcode 0000011 with mem_ready low for 2 cycles in MEMRD: MEMRD lasts 3 cycles with addr_src=1, then MEMWB with result_src=1 and reg_we=1. Total 7 cycles.
- opcode 1100011:
  - alu_cond=1 gives pc_we=1 in BRANCH;
  - alu_cond=0 gives pc_we=0;
  - both return to FETCH after 3 cycles.
- opcode 1100111: JALADR (srca=2, srcb=1), then JAL (pc_we=1, result_src=0), then ALUWB (reg_we=1).
- opcode 1111111: TRAP with illegal=1 held for 20 cycles; reset low clears illegal and returns to FETCH.
